simplebus_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the core's SimpleBus; lets the IFU and LSU share one memory port.
- Masters issue single-cycle reqValid pulses. The arbiter queues one request per master, forwards requests one at a time, and routes the slave's respValid/rdata back to the owning master.
- Includes a response timeout so a dead slave cannot hang the core.

---
 rtl/simplebus_arbiter.sv | 272 +++++++++++++++++++++++++++
 tb/tb_simplebus_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simplebus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : simplebus_arbiter
// Brief    : Two-master (IFU, LSU) to one-slave SimpleBus arbiter. Holds one
//            pending request per master, forwards one at a time with
//            round-robin tie breaking, routes the response back to the owner
//            and forces an error response if the slave stays silent.
// Revision : 1.0 - initial release
// ============================================================================
module simplebus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic                clock,
  input  logic                reset,
  // IFU
  input  logic [ADDR_W-1:0]   ifu_addr,
  input  logic                ifu_reqValid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_respValid,
  output logic                ifu_err,
  // LSU
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  input  logic                lsu_wen,
  input  logic                lsu_reqValid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_respValid,
  output logic                lsu_err,
  // Slave
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic                mem_wen,
  output logic                mem_reqValid,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_respValid,
  // Status
  output logic                busy,
  output logic                owner,
  output logic                overflow
);

  localparam int c_MASK_W = DATA_W / 8;
  // Last WAIT count before the forced error response (unused when TIMEOUT == 0)
  localparam logic [CNT_W-1:0] c_TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Pending slots
  logic                r_ifu_pend;
  logic [ADDR_W-1:0]   r_ifu_addr;
  logic                r_lsu_pend;
  logic [ADDR_W-1:0]   r_lsu_addr;
  logic [DATA_W-1:0]   r_lsu_wdata;
  logic [c_MASK_W-1:0] r_lsu_wmask;
  logic                r_lsu_wen;

  // Registered outputs
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [c_MASK_W-1:0] r_mem_wmask;
  logic                r_mem_wen;
  logic                r_mem_req;
  logic [DATA_W-1:0]   r_ifu_rdata;
  logic                r_ifu_resp;
  logic                r_ifu_err;
  logic [DATA_W-1:0]   r_lsu_rdata;
  logic                r_lsu_resp;
  logic                r_lsu_err;
  logic                r_busy;
  logic                r_owner;
  logic                r_overflow;
  logic [CNT_W-1:0]    r_cnt;

  // Decode of the current cycle
  logic w_grant_ifu;
  logic w_grant_lsu;
  logic w_resp_ok;
  logic w_resp_to;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state, grant and response-event decode
  always_comb begin
    w_state_nxt = r_state;
    w_grant_ifu = 1'b0;
    w_grant_lsu = 1'b0;
    w_resp_ok   = 1'b0;
    w_resp_to   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_ifu_pend && r_lsu_pend) begin
          // Round-robin: the master that did not hold the last grant wins
          if (r_owner) w_grant_ifu = 1'b1;
          else         w_grant_lsu = 1'b1;
          w_state_nxt = S_REQ;
        end else if (r_ifu_pend) begin
          w_grant_ifu = 1'b1;
          w_state_nxt = S_REQ;
        end else if (r_lsu_pend) begin
          w_grant_lsu = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_respValid) begin
          w_resp_ok   = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_respValid) begin
          w_resp_ok   = 1'b1;
          w_state_nxt = S_RESP;
        end else if ((TIMEOUT != 0) && (r_cnt == c_TO_LAST)) begin
          w_resp_to   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // IFU pending slot: a pulse coinciding with the grant refills the slot
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ifu_pend <= 1'b0;
      r_ifu_addr <= '0;
    end else if (ifu_reqValid && (!r_ifu_pend || w_grant_ifu)) begin
      r_ifu_pend <= 1'b1;
      r_ifu_addr <= ifu_addr;
    end else if (w_grant_ifu) begin
      r_ifu_pend <= 1'b0;
    end
  end

  // LSU pending slot: same capture rule as the IFU slot
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_lsu_pend  <= 1'b0;
      r_lsu_addr  <= '0;
      r_lsu_wdata <= '0;
      r_lsu_wmask <= '0;
      r_lsu_wen   <= 1'b0;
    end else if (lsu_reqValid && (!r_lsu_pend || w_grant_lsu)) begin
      r_lsu_pend  <= 1'b1;
      r_lsu_addr  <= lsu_addr;
      r_lsu_wdata <= lsu_wdata;
      r_lsu_wmask <= lsu_wmask;
      r_lsu_wen   <= lsu_wen;
    end else if (w_grant_lsu) begin
      r_lsu_pend  <= 1'b0;
    end
  end

  // Sticky overflow: a pulse arrived while its slot was still occupied
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if ((ifu_reqValid && r_ifu_pend && !w_grant_ifu) ||
                 (lsu_reqValid && r_lsu_pend && !w_grant_lsu)) begin
      r_overflow <= 1'b1;
    end
  end

  // Slave request: mem_* loaded on grant and held until the next grant
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wmask <= '0;
      r_mem_wen   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_owner     <= 1'b1;
    end else begin
      r_mem_req <= w_grant_ifu | w_grant_lsu;
      if (w_grant_ifu) begin
        r_mem_addr  <= r_ifu_addr;
        r_mem_wdata <= '0;
        r_mem_wmask <= '0;
        r_mem_wen   <= 1'b0;
        r_owner     <= 1'b0;
      end else if (w_grant_lsu) begin
        r_mem_addr  <= r_lsu_addr;
        r_mem_wdata <= r_lsu_wdata;
        r_mem_wmask <= r_lsu_wmask;
        r_mem_wen   <= r_lsu_wen;
        r_owner     <= 1'b1;
      end
    end
  end

  // Timeout counter: zeroed in REQ, counts silent WAIT cycles
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                   r_cnt <= '0;
    else if (r_state == S_REQ)                    r_cnt <= '0;
    else if (r_state == S_WAIT && !mem_respValid) r_cnt <= r_cnt + CNT_W'(1);
  end

  // Response routing: one-cycle pulse to the owner, zeros everywhere else
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ifu_rdata <= '0;
      r_ifu_resp  <= 1'b0;
      r_ifu_err   <= 1'b0;
      r_lsu_rdata <= '0;
      r_lsu_resp  <= 1'b0;
      r_lsu_err   <= 1'b0;
    end else begin
      r_ifu_rdata <= '0;
      r_ifu_resp  <= 1'b0;
      r_ifu_err   <= 1'b0;
      r_lsu_rdata <= '0;
      r_lsu_resp  <= 1'b0;
      r_lsu_err   <= 1'b0;
      if (w_resp_ok || w_resp_to) begin
        if (!r_owner) begin
          r_ifu_resp  <= 1'b1;
          r_ifu_err   <= w_resp_to;
          r_ifu_rdata <= w_resp_ok ? mem_rdata : '0;
        end else begin
          r_lsu_resp  <= 1'b1;
          r_lsu_err   <= w_resp_to;
          // Stores return no data
          r_lsu_rdata <= (w_resp_ok && !r_mem_wen) ? mem_rdata : '0;
        end
      end
    end
  end

  // Busy mirrors the state the FSM is entering
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_busy <= 1'b0;
    else        r_busy <= (w_state_nxt != S_IDLE);
  end

  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign mem_wmask     = r_mem_wmask;
  assign mem_wen       = r_mem_wen;
  assign mem_reqValid  = r_mem_req;
  assign ifu_rdata     = r_ifu_rdata;
  assign ifu_respValid = r_ifu_resp;
  assign ifu_err       = r_ifu_err;
  assign lsu_rdata     = r_lsu_rdata;
  assign lsu_respValid = r_lsu_resp;
  assign lsu_err       = r_lsu_err;
  assign busy          = r_busy;
  assign owner         = r_owner;
  assign overflow      = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_simplebus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_simplebus_arbiter
// Brief    : Scoreboard bench for simplebus_arbiter (TIMEOUT = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_simplebus_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wen;
    logic        own;
  } mem_exp_t;

  typedef struct {
    logic        lsu;
    logic [31:0] rdata;
    logic        err;
  } resp_exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ifu_addr = '0;
  logic        ifu_reqValid = 1'b0;
  logic [31:0] ifu_rdata;
  logic        ifu_respValid;
  logic        ifu_err;
  logic [31:0] lsu_addr = '0;
  logic [31:0] lsu_wdata = '0;
  logic [3:0]  lsu_wmask = '0;
  logic        lsu_wen = 1'b0;
  logic        lsu_reqValid = 1'b0;
  logic [31:0] lsu_rdata;
  logic        lsu_respValid;
  logic        lsu_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_wen;
  logic        mem_reqValid;
  logic [31:0] mem_rdata;
  logic        mem_respValid;
  logic        busy;
  logic        owner;
  logic        overflow;

  // Slave model and manual late-response drivers are merged here
  logic        sl_resp = 1'b0;
  logic [31:0] sl_data = '0;
  logic        man_resp = 1'b0;
  logic [31:0] man_data = '0;
  logic        slave_mute = 1'b0;
  assign mem_respValid = sl_resp | man_resp;
  assign mem_rdata     = sl_resp ? sl_data : man_data;

  mem_exp_t    exp_mem_q[$];
  resp_exp_t   exp_resp_q[$];
  logic [31:0] slave_data_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int t_memreq = 0;
  int t_ifu_resp = 0;
  int t_lsu_resp = 0;
  int n_memreq = 0;
  int n_resp = 0;
  int t_req = 0;

  simplebus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .CNT_W(8)
  ) dut (
    .clock(clock), .reset(reset),
    .ifu_addr(ifu_addr), .ifu_reqValid(ifu_reqValid),
    .ifu_rdata(ifu_rdata), .ifu_respValid(ifu_respValid), .ifu_err(ifu_err),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_wen(lsu_wen), .lsu_reqValid(lsu_reqValid),
    .lsu_rdata(lsu_rdata), .lsu_respValid(lsu_respValid), .lsu_err(lsu_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_wen(mem_wen), .mem_reqValid(mem_reqValid),
    .mem_rdata(mem_rdata), .mem_respValid(mem_respValid),
    .busy(busy), .owner(owner), .overflow(overflow)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_mem(input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] wm, input logic we, input logic ow);
    mem_exp_t e;
    e.addr = a; e.wdata = wd; e.wmask = wm; e.wen = we; e.own = ow;
    exp_mem_q.push_back(e);
  endtask

  task automatic push_resp(input logic l, input logic [31:0] d, input logic er);
    resp_exp_t e;
    e.lsu = l; e.rdata = d; e.err = er;
    exp_resp_q.push_back(e);
  endtask

  // Wait (bounded) until every expected transaction was seen and the FSM is idle
  task automatic wait_done(input string nm);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (exp_mem_q.size() == 0 && exp_resp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, {63'd0, ok}, 64'd1);
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // Monitor: compares every slave request and master response to the queues
  always @(negedge clock) begin
    if (reset) begin
      if (mem_reqValid) begin
        n_memreq++;
        t_memreq = cyc;
        if (exp_mem_q.size() == 0) begin
          chk("unexpected mem_reqValid", 64'd1, 64'd0);
        end else begin
          mem_exp_t e;
          e = exp_mem_q.pop_front();
          chk("mem_addr",  {32'd0, mem_addr},  {32'd0, e.addr});
          chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, e.wdata});
          chk("mem_wmask", {60'd0, mem_wmask}, {60'd0, e.wmask});
          chk("mem_wen",   {63'd0, mem_wen},   {63'd0, e.wen});
          chk("owner",     {63'd0, owner},     {63'd0, e.own});
        end
      end
      if (ifu_respValid || lsu_respValid) begin
        n_resp++;
        if (ifu_respValid) t_ifu_resp = cyc;
        if (lsu_respValid) t_lsu_resp = cyc;
        if (exp_resp_q.size() == 0) begin
          chk("unexpected respValid", 64'd1, 64'd0);
        end else begin
          resp_exp_t e;
          e = exp_resp_q.pop_front();
          if (!e.lsu) begin
            chk("ifu_respValid", {63'd0, ifu_respValid}, 64'd1);
            chk("ifu_rdata", {32'd0, ifu_rdata}, {32'd0, e.rdata});
            chk("ifu_err",   {63'd0, ifu_err},   {63'd0, e.err});
            chk("lsu quiet", {31'd0, lsu_respValid, lsu_rdata, lsu_err}, 64'd0);
          end else begin
            chk("lsu_respValid", {63'd0, lsu_respValid}, 64'd1);
            chk("lsu_rdata", {32'd0, lsu_rdata}, {32'd0, e.rdata});
            chk("lsu_err",   {63'd0, lsu_err},   {63'd0, e.err});
            chk("ifu quiet", {31'd0, ifu_respValid, ifu_rdata, ifu_err}, 64'd0);
          end
        end
      end
    end
  end

  // Slave: answers two cycles after each mem_reqValid unless muted
  initial begin
    logic [31:0] d;
    forever begin
      @(negedge clock);
      if (reset && mem_reqValid && !slave_mute) begin
        d = (slave_data_q.size() != 0) ? slave_data_q.pop_front() : 32'h0;
        @(posedge clock);
        @(posedge clock);
        #1;
        sl_resp = 1'b1;
        sl_data = d;
        tick();
        sl_resp = 1'b0;
        sl_data = '0;
      end
    end
  end

  initial begin
    // ---------------- reset state ----------------
    repeat (2) @(negedge clock);
    chk("rst busy",     {63'd0, busy},         64'd0);
    chk("rst owner",    {63'd0, owner},        64'd1);
    chk("rst overflow", {63'd0, overflow},     64'd0);
    chk("rst mem_req",  {63'd0, mem_reqValid}, 64'd0);
    chk("rst mem_addr", {32'd0, mem_addr},     64'd0);
    chk("rst resp",     {62'd0, ifu_respValid, lsu_respValid}, 64'd0);
    tick();
    reset = 1'b1;
    tick();

    // ---------------- single IFU fetch ----------------
    ifu_addr = 32'h8000_0000; ifu_reqValid = 1'b1; t_req = cyc;
    push_mem(32'h8000_0000, 32'h0, 4'h0, 1'b0, 1'b0);
    push_resp(1'b0, 32'h0000_0413, 1'b0);
    slave_data_q.push_back(32'h0000_0413);
    tick();
    ifu_reqValid = 1'b0;
    wait_done("fetch done");
    chk("fetch req latency",  t_memreq - t_req, 64'd2);
    chk("fetch resp latency", t_ifu_resp - t_memreq, 64'd3);

    // ---------------- simultaneous requests (fresh owner = 1) ----------------
    do_reset();
    ifu_addr = 32'h8000_0004; ifu_reqValid = 1'b1;
    lsu_addr = 32'h8000_1000; lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
    lsu_reqValid = 1'b1;
    push_mem(32'h8000_0004, 32'h0, 4'h0, 1'b0, 1'b0);
    push_mem(32'h8000_1000, 32'h0, 4'h0, 1'b0, 1'b1);
    push_resp(1'b0, 32'hA0A0_0001, 1'b0);
    push_resp(1'b1, 32'hB0B0_0002, 1'b0);
    slave_data_q.push_back(32'hA0A0_0001);
    slave_data_q.push_back(32'hB0B0_0002);
    tick();
    ifu_reqValid = 1'b0; lsu_reqValid = 1'b0;
    wait_done("dual done");
    chk("second grant gap", t_memreq - t_ifu_resp, 64'd2);
    chk("dual no overflow", {63'd0, overflow}, 64'd0);

    // ---------------- LSU store ----------------
    tick();
    lsu_addr = 32'h8000_2000; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
    lsu_wen = 1'b1; lsu_reqValid = 1'b1;
    push_mem(32'h8000_2000, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1);
    push_resp(1'b1, 32'h0, 1'b0);
    slave_data_q.push_back(32'h1234_5678);
    tick();
    lsu_reqValid = 1'b0; lsu_wen = 1'b0;
    wait_done("store done");

    // ---------------- timeout ----------------
    tick();
    slave_mute = 1'b1;
    ifu_addr = 32'h8000_3000; ifu_reqValid = 1'b1;
    push_mem(32'h8000_3000, 32'h0, 4'h0, 1'b0, 1'b0);
    push_resp(1'b0, 32'h0, 1'b1);
    tick();
    ifu_reqValid = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clock);
        if (ifu_respValid) begin
          seen = 1'b1;
          break;
        end
      end
      chk("timeout resp seen", {63'd0, seen}, 64'd1);
      chk("busy in resp", {63'd0, busy}, 64'd1);
      @(negedge clock);
      chk("busy after resp", {63'd0, busy}, 64'd0);
    end
    chk("timeout latency", t_ifu_resp - t_memreq, 64'd5);
    slave_mute = 1'b0;
    wait_done("timeout done");

    // ---------------- overflow ----------------
    tick();
    chk("overflow clear before", {63'd0, overflow}, 64'd0);
    ifu_addr = 32'h8000_3100; ifu_reqValid = 1'b1;
    push_mem(32'h8000_3100, 32'h0, 4'h0, 1'b0, 1'b0);
    push_mem(32'h8000_4000, 32'h1111_1111, 4'h3, 1'b0, 1'b1);
    push_resp(1'b0, 32'hC0C0_0003, 1'b0);
    push_resp(1'b1, 32'hD0D0_0004, 1'b0);
    slave_data_q.push_back(32'hC0C0_0003);
    slave_data_q.push_back(32'hD0D0_0004);
    tick();
    ifu_reqValid = 1'b0;
    tick();
    lsu_addr = 32'h8000_4000; lsu_wdata = 32'h1111_1111; lsu_wmask = 4'h3;
    lsu_wen = 1'b0; lsu_reqValid = 1'b1;
    tick();
    lsu_addr = 32'h8000_5000; lsu_wdata = 32'h2222_2222; lsu_wmask = 4'hC;
    tick();
    lsu_reqValid = 1'b0;
    wait_done("overflow done");
    chk("overflow set", {63'd0, overflow}, 64'd1);

    // ---------------- reset mid-WAIT ----------------
    tick();
    slave_mute = 1'b1;
    ifu_addr = 32'h8000_6000; ifu_reqValid = 1'b1;
    push_mem(32'h8000_6000, 32'h0, 4'h0, 1'b0, 1'b0);
    tick();
    ifu_reqValid = 1'b0;
    tick();
    lsu_addr = 32'h8000_7000; lsu_reqValid = 1'b1;
    tick();
    lsu_reqValid = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("async rst busy",     {63'd0, busy},     64'd0);
    chk("async rst overflow", {63'd0, overflow}, 64'd0);
    chk("async rst owner",    {63'd0, owner},    64'd1);
    tick();
    reset = 1'b1;
    begin
      int memreq0;
      int resp0;
      memreq0 = n_memreq;
      resp0   = n_resp;
      man_resp = 1'b1; man_data = 32'hBAD0_BAD0;
      tick();
      man_resp = 1'b0; man_data = '0;
      repeat (8) @(negedge clock);
      chk("late resp ignored", n_resp - resp0, 64'd0);
      chk("slots cleared", n_memreq - memreq0, 64'd0);
      chk("post rst busy", {63'd0, busy}, 64'd0);
      chk("post rst mem_addr", {32'd0, mem_addr}, 64'd0);
    end
    slave_mute = 1'b0;

    chk("mem queue drained",  exp_mem_q.size(),  64'd0);
    chk("resp queue drained", exp_resp_q.size(), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
